// File: rtl/chara_hit_control_pkg.sv
// Shared game constants, hit FSM state encoding and small helpers.
// Used by chara_hit_control and the frame tick generator.
package chara_hit_control_pkg;

   localparam int H_LAST = 639;
   localparam int V_LAST = 479;

   localparam logic [11:0] TRANSPARENT_KEY = 12'h0f0;

   localparam int STAGE_FIRST = 0;
   localparam int STAGE_LAST  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIVE = 2'd1,
      ST_INV   = 2'd2,
      ST_DEAD  = 2'd3
   } hit_state_e;

   function automatic logic [7:0] sat_inc8(
      input logic [7:0] v,
      input logic       en
   );
      return (v == 8'hff) ? v : v + 8'(en);
   endfunction

endpackage

// File: rtl/chara_hit_control_frame_tick.sv
// One-cycle frame tick at the last visible pixel of a scan.
// Edge-qualified so a held last coordinate yields a single tick.
module frame_tick_gen
   import chara_hit_control_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic       tick
);

   logic at_last;
   logic at_last_q;

   assign at_last = (pixel_x == 10'(H_LAST))
                 && (pixel_y == 10'(V_LAST));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) at_last_q <= 1'b0;
      else          at_last_q <= at_last;
   end

   assign tick = at_last & ~at_last_q;

endmodule

// File: rtl/chara_hit_control.sv
// Character collision and life manager; optional blink via
// CHARA_HIT_BLINK_EN (undefined: blink tied low).
module chara_hit_control
   import chara_hit_control_pkg::*;
#(
   parameter int          LIVES_INIT  = 3,
   parameter int          INV_FRAMES  = 120,
   parameter int          MIN_OVERLAP = 16,
   parameter int          PIPE_DLY    = 3,
   parameter logic [11:0] TRANSPARENT = TRANSPARENT_KEY
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  stage,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        chara_region,
   input  logic [2:0]  enemy_region,
   input  logic [11:0] enemy_rgb,
   output logic [1:0]  lives,
   output logic        hit_pulse,
   output logic        invincible,
   output logic        blink,
   output logic        game_over
);

   localparam int INV_W = $clog2(INV_FRAMES + 1);

   localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INV_FRAMES);
   localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);
   localparam logic [7:0]       MIN_OV    = 8'(MIN_OVERLAP);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] ALIVE = ST_ALIVE;
   localparam logic [1:0] INV   = ST_INV;
   localparam logic [1:0] DEAD  = ST_DEAD;

   logic             tick;
   logic [PIPE_DLY-1:0] chara_sr;
   logic [PIPE_DLY-1:0] enemy_sr;
   logic             ovl;
   logic [7:0]       ov_cnt;
   logic [7:0]       ov_sum;
   logic             hit_now;
   logic [3:0]       stage_q;
   logic             stage_chg;
   logic [1:0]       state;
   logic [INV_W-1:0] inv_cnt;

   frame_tick_gen u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .tick    (tick)
   );

   // Region bits are delayed to line up with the colour pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chara_sr <= '0;
         enemy_sr <= '0;
      end else begin
         chara_sr[0] <= chara_region;
         enemy_sr[0] <= |enemy_region;
         for (int i = 1; i < PIPE_DLY; i++) begin
            chara_sr[i] <= chara_sr[i-1];
            enemy_sr[i] <= enemy_sr[i-1];
         end
      end
   end

   assign ovl = chara_sr[PIPE_DLY-1]
             & enemy_sr[PIPE_DLY-1]
             & (enemy_rgb != TRANSPARENT);

   assign ov_sum    = sat_inc8(ov_cnt, ovl);
   assign hit_now   = tick && (ov_sum >= MIN_OV);
   assign stage_chg = (stage != stage_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ov_cnt  <= 8'd0;
         stage_q <= 4'd0;
      end else begin
         ov_cnt  <= (tick || stage_chg) ? 8'd0 : ov_sum;
         stage_q <= stage;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         lives      <= LIVES_RST;
         inv_cnt    <= '0;
         hit_pulse  <= 1'b0;
         invincible <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         if (stage == 4'd0) begin
            state      <= IDLE;
            lives      <= LIVES_RST;
            inv_cnt    <= '0;
            invincible <= 1'b0;
            game_over  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state      <= INV;
                  inv_cnt    <= INV_LOAD;
                  invincible <= 1'b1;
               end
               ALIVE: begin
                  // Stage change wins over a same-cycle hit.
                  if (stage_chg) begin
                     state      <= INV;
                     inv_cnt    <= INV_LOAD;
                     invincible <= 1'b1;
                  end else if (hit_now && lives != 2'd0) begin
                     lives     <= lives - 2'd1;
                     hit_pulse <= 1'b1;
                     if (lives == 2'd1) begin
                        state     <= DEAD;
                        game_over <= 1'b1;
                     end else begin
                        state      <= INV;
                        inv_cnt    <= INV_LOAD;
                        invincible <= 1'b1;
                     end
                  end
               end
               INV: begin
                  if (stage_chg) begin
                     inv_cnt <= INV_LOAD;
                  end else if (tick) begin
                     if (inv_cnt <= INV_W'(1)) begin
                        state      <= ALIVE;
                        inv_cnt    <= '0;
                        invincible <= 1'b0;
                     end else begin
                        inv_cnt <= inv_cnt - INV_W'(1);
                     end
                  end
               end
               DEAD: begin
                  game_over <= 1'b1;
               end
            endcase
         end
      end
   end

`ifdef CHARA_HIT_BLINK_EN
   logic [1:0] blk_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          blk_cnt <= 2'd0;
      else if (state != INV) blk_cnt <= 2'd0;
      else if (tick)         blk_cnt <= blk_cnt + 2'd1;
   end

   assign blink = blk_cnt[1];
`else
   assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_chara_hit_control.sv
// Directed bench for chara_hit_control with default parameters.
// Frames are compressed: overlap burst, flush, one tick cycle.
module tb_chara_hit_control;

   localparam int PIPE = 3;
   localparam logic [11:0] OPAQUE = 12'h123;
   localparam logic [11:0] KEY    = 12'h0f0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  stage;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        chara_region;
   logic [2:0]  enemy_region;
   logic [11:0] enemy_rgb;
   logic [1:0]  lives;
   logic        hit_pulse;
   logic        invincible;
   logic        blink;
   logic        game_over;

   int   errs   = 0;
   int   checks = 0;
   logic last_hp;

   chara_hit_control dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stage        (stage),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .chara_region (chara_region),
      .enemy_region (enemy_region),
      .enemy_rgb    (enemy_rgb),
      .lives        (lives),
      .hit_pulse    (hit_pulse),
      .invincible   (invincible),
      .blink        (blink),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(
      input string       tag,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // n overlapping pixels, then the tick with stage stg applied.
   task automatic frame(
      input int          n,
      input logic [11:0] rgb,
      input logic [3:0]  stg
   );
      enemy_rgb = rgb;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chara_region = 1'b1;
         enemy_region = 3'b010;
      end
      @(negedge clk);
      chara_region = 1'b0;
      enemy_region = 3'b000;
      repeat (PIPE + 1) @(negedge clk);
      stage   = stg;
      pixel_x = 10'd639;
      pixel_y = 10'd479;
      @(negedge clk);
      pixel_x = 10'd0;
      pixel_y = 10'd0;
      last_hp = hit_pulse;
   endtask

   task automatic empty_frames(input int k);
      for (int i = 0; i < k; i++) frame(0, OPAQUE, stage);
   endtask

   task automatic hit_and_recover(input logic [1:0] exp_lives);
      frame(16, OPAQUE, stage);
      expect_eq("hit_pulse", 32'(last_hp), 32'd1);
      expect_eq("hit_lives", 32'(lives), 32'(exp_lives));
      empty_frames(120);
      expect_eq("recovered", 32'(invincible), 32'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      stage        = 4'd0;
      pixel_x      = 10'd0;
      pixel_y      = 10'd0;
      chara_region = 1'b0;
      enemy_region = 3'b000;
      enemy_rgb    = 12'h000;
      last_hp      = 1'b0;
      repeat (3) @(negedge clk);
      expect_eq("rst_lives", 32'(lives), 32'd3);
      expect_eq("rst_hit", 32'(hit_pulse), 32'd0);
      expect_eq("rst_inv", 32'(invincible), 32'd0);
      expect_eq("rst_blink", 32'(blink), 32'd0);
      expect_eq("rst_go", 32'(game_over), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      expect_eq("idle_inv", 32'(invincible), 32'd0);

      stage = 4'd4;
      @(negedge clk);
      expect_eq("start_inv", 32'(invincible), 32'd1);
      empty_frames(119);
      expect_eq("inv_119", 32'(invincible), 32'd1);
      empty_frames(1);
      expect_eq("inv_120", 32'(invincible), 32'd0);

      frame(15, OPAQUE, stage);
      expect_eq("ov15_hit", 32'(last_hp), 32'd0);
      expect_eq("ov15_lives", 32'(lives), 32'd3);
      frame(100, KEY, stage);
      expect_eq("key_hit", 32'(last_hp), 32'd0);
      expect_eq("key_lives", 32'(lives), 32'd3);

      frame(16, OPAQUE, stage);
      expect_eq("ov16_hit", 32'(last_hp), 32'd1);
      expect_eq("ov16_lives", 32'(lives), 32'd2);
      expect_eq("ov16_inv", 32'(invincible), 32'd1);
      @(negedge clk);
      expect_eq("hit_1cyc", 32'(hit_pulse), 32'd0);
      for (int k = 1; k <= 119; k++) begin
         frame(0, OPAQUE, stage);
`ifdef CHARA_HIT_BLINK_EN
         expect_eq("blink_inv", 32'(blink), 32'((k >> 1) & 1));
`else
         expect_eq("blink_off", 32'(blink), 32'd0);
`endif
      end
      expect_eq("hold_inv", 32'(invincible), 32'd1);
      empty_frames(1);
      @(negedge clk);
      expect_eq("alive_inv", 32'(invincible), 32'd0);
      expect_eq("alive_blink", 32'(blink), 32'd0);

      frame(20, OPAQUE, 4'd5);
      expect_eq("chg_hit", 32'(last_hp), 32'd0);
      expect_eq("chg_lives", 32'(lives), 32'd2);
      expect_eq("chg_inv", 32'(invincible), 32'd1);

      empty_frames(70);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      expect_eq("arst_lives", 32'(lives), 32'd3);
      expect_eq("arst_inv", 32'(invincible), 32'd0);
      expect_eq("arst_go", 32'(game_over), 32'd0);
      expect_eq("arst_hit", 32'(hit_pulse), 32'd0);
      expect_eq("arst_blink", 32'(blink), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      expect_eq("rel_inv", 32'(invincible), 32'd1);
      empty_frames(120);
      expect_eq("rel_alive", 32'(invincible), 32'd0);

      hit_and_recover(2'd2);
      hit_and_recover(2'd1);
      frame(16, OPAQUE, stage);
      expect_eq("last_hit", 32'(last_hp), 32'd1);
      expect_eq("dead_lives", 32'(lives), 32'd0);
      expect_eq("dead_go", 32'(game_over), 32'd1);
      expect_eq("dead_inv", 32'(invincible), 32'd0);
      frame(50, OPAQUE, stage);
      expect_eq("frz_hit", 32'(last_hp), 32'd0);
      expect_eq("frz_lives", 32'(lives), 32'd0);
      expect_eq("frz_go", 32'(game_over), 32'd1);

      stage = 4'd0;
      @(negedge clk);
      expect_eq("idle_lives", 32'(lives), 32'd3);
      expect_eq("idle_go", 32'(game_over), 32'd0);
      frame(30, OPAQUE, stage);
      expect_eq("idle_nohit", 32'(last_hp), 32'd0);
      expect_eq("idle_keep", 32'(lives), 32'd3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
